// File: rtl/fpu_normalize_sequencer_pkg.sv
// fpu_normalize_sequencer_pkg: shared widths, shift constants and sequencer states for the normalizer
package fpu_normalize_sequencer_pkg;
    localparam int MANT_W        = 64;
    localparam int EXP_W         = 15;
    localparam int BYTE_SHIFT    = 8;
    localparam int MAX_BIT_SHIFT = 7;
    typedef enum logic [1:0] {IDLE, BYTE, BIT, DONE} state_t;
endpackage

// File: rtl/fpu_normalize_sequencer_if.sv
// fpu_normalize_sequencer_if: operand/result handshake bundle for the normalizer
interface fpu_normalize_sequencer_if import fpu_normalize_sequencer_pkg::*; ();
    logic              start;
    logic [MANT_W-1:0] mant_in;
    logic [EXP_W-1:0]  exp_in;
    logic              ready;
    logic              done;
    logic [MANT_W-1:0] mant_out;
    logic [EXP_W-1:0]  exp_out;
    logic              zero;
    logic              underflow;
    modport master (output start, mant_in, exp_in, input ready, done, mant_out, exp_out, zero, underflow);
    modport slave  (input start, mant_in, exp_in, output ready, done, mant_out, exp_out, zero, underflow);
endinterface

// File: rtl/multiplexer_based_bit_shifter_right.sv
// multiplexer_based_bit_shifter_right: 0-7 bit log shifter moving data toward bit 63, zero fill
module multiplexer_based_bit_shifter_right import fpu_normalize_sequencer_pkg::*; (
    input  logic [MANT_W-1:0] d,
    input  logic [2:0]        amt,
    output logic [MANT_W-1:0] q
);
    logic [MANT_W-1:0] s1, s2;
    assign s1 = amt[0] ? {d[MANT_W-2:0], 1'b0} : d;
    assign s2 = amt[1] ? {s1[MANT_W-3:0], 2'b0} : s1;
    assign q  = amt[2] ? {s2[MANT_W-5:0], 4'b0} : s2;
endmodule

// File: rtl/fpu_normalize_sequencer.sv
// fpu_normalize_sequencer: multi-cycle byte/bit mantissa normalizer with bounded exponent decrement
module fpu_normalize_sequencer import fpu_normalize_sequencer_pkg::*; (
    input logic clk,
    input logic reset,
    fpu_normalize_sequencer_if.slave bus
);
    state_t            state, state_nxt;
    logic [MANT_W-1:0] m, m_nxt, sh, mant_q;
    logic [EXP_W-1:0]  e, e_nxt, exp_q;
    logic [2:0]        lz, k;
    logic              zero_q, uf_q;

    function automatic logic [2:0] lz_byte(input logic [7:0] b);
        logic [2:0] n;
        n = 3'(MAX_BIT_SHIFT);
        for (int i = 0; i < 8; i++)
            if (b[i]) n = 3'(7 - i);
        return n;
    endfunction

    assign lz = lz_byte(m[MANT_W-1:MANT_W-8]);
    assign k  = (e < EXP_W'(lz)) ? e[2:0] : lz;

    multiplexer_based_bit_shifter_right u_shift (.d(m), .amt(k), .q(sh));

    always_comb begin
        state_nxt = state;
        m_nxt     = m;
        e_nxt     = e;
        case (state)
            IDLE: if (bus.start) begin
                m_nxt     = bus.mant_in;
                e_nxt     = (bus.mant_in == '0) ? '0 : bus.exp_in;
                state_nxt = (bus.mant_in == '0) ? DONE : BYTE;
            end
            BYTE: if (m[MANT_W-1:MANT_W-8] == 8'd0 && e >= EXP_W'(BYTE_SHIFT)) begin
                m_nxt = m << BYTE_SHIFT;
                e_nxt = e - EXP_W'(BYTE_SHIFT);
            end else begin
                state_nxt = BIT;
            end
            BIT: begin
                m_nxt     = sh;
                e_nxt     = e - EXP_W'(k);
                state_nxt = (sh[MANT_W-1] || e_nxt == '0) ? DONE : BYTE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // results are captured on entry to DONE so they are valid while done is high
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            m      <= '0;
            e      <= '0;
            mant_q <= '0;
            exp_q  <= '0;
            zero_q <= 1'b0;
            uf_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            m     <= m_nxt;
            e     <= e_nxt;
            if (state != DONE && state_nxt == DONE) begin
                mant_q <= m_nxt;
                exp_q  <= e_nxt;
                zero_q <= m_nxt == '0;
                uf_q   <= e_nxt == '0 && !m_nxt[MANT_W-1] && m_nxt != '0;
            end else if (state == IDLE && bus.start) begin
                zero_q <= 1'b0;
                uf_q   <= 1'b0;
            end
        end
    end

    assign bus.ready     = state == IDLE;
    assign bus.done      = state == DONE;
    assign bus.mant_out  = mant_q;
    assign bus.exp_out   = exp_q;
    assign bus.zero      = zero_q;
    assign bus.underflow = uf_q;
endmodule

// File: tb/tb_fpu_normalize_sequencer.sv
// tb_fpu_normalize_sequencer: directed and random checks against a shift-count reference model
module tb_fpu_normalize_sequencer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;

    fpu_normalize_sequencer_if bus ();
    fpu_normalize_sequencer dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    function automatic int lzc(input logic [63:0] v);
        for (int i = 63; i >= 0; i--)
            if (v[i]) return 63 - i;
        return 64;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [63:0] mant, input logic [14:0] expo, input bit intrude);
        int lz, s, lat, cnt, dones;
        logic [63:0] em;
        logic [14:0] ee;
        lz  = lzc(mant);
        s   = (lz < int'(expo)) ? lz : int'(expo);
        em  = (mant == 0) ? 64'd0 : mant << s;
        ee  = (mant == 0) ? 15'd0 : expo - 15'(s);
        lat = (mant == 0) ? 1 : 3 + (((lz / 8) < (int'(expo) / 8)) ? lz / 8 : int'(expo) / 8);
        bus.start   = 1'b1;
        bus.mant_in = mant;
        bus.exp_in  = expo;
        step();
        bus.start   = 1'b0;
        bus.mant_in = $urandom();
        bus.exp_in  = 15'($urandom());
        cnt = 1;
        while (!bus.done && cnt < 40) begin
            if (intrude && cnt == 1) begin
                bus.start   = 1'b1;
                bus.mant_in = 64'h0000_0F00_0000_0000;
                bus.exp_in  = 15'h0100;
            end
            step();
            bus.start = 1'b0;
            cnt++;
        end
        check("latency", 64'(cnt), 64'(lat));
        check("mant_out", bus.mant_out, em);
        check("exp_out", 64'(bus.exp_out), 64'(ee));
        check("zero", 64'(bus.zero), 64'(mant == 0));
        check("underflow", 64'(bus.underflow), 64'(mant != 0 && ee == 0 && !em[63]));
        step();
        check("done_pulse", 64'(bus.done), 64'd0);
        check("ready_after", 64'(bus.ready), 64'd1);
        if (intrude) begin
            dones = 0;
            for (int i = 0; i < 14; i++) begin
                if (bus.done) dones++;
                step();
            end
            check("extra_done", 64'(dones), 64'd0);
            check("held_mant", bus.mant_out, em);
        end
    endtask

    initial begin
        int dones;
        logic [63:0] r;
        bus.start   = 1'b0;
        bus.mant_in = '0;
        bus.exp_in  = '0;
        step();
        step();
        check("rst_ready", 64'(bus.ready), 64'd1);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_mant", bus.mant_out, 64'd0);
        check("rst_exp", 64'(bus.exp_out), 64'd0);
        check("rst_zero", 64'(bus.zero), 64'd0);
        check("rst_uf", 64'(bus.underflow), 64'd0);
        reset = 1'b0;
        step();
        run_op(64'h8000_0000_0000_0000, 15'h3FFF, 1'b0);
        run_op(64'h0000_0000_0001_0000, 15'h4000, 1'b0);
        run_op(64'h0, 15'h1234, 1'b0);
        run_op(64'h0000_0000_0000_00F0, 15'h0005, 1'b0);
        run_op(64'h0000_0000_0000_0001, 15'h7FFF, 1'b0);
        run_op(64'h0000_0000_0000_0123, 15'h0000, 1'b0);
        run_op(64'h0000_0000_0000_0001, 15'h4000, 1'b1);
        bus.start   = 1'b1;
        bus.mant_in = 64'h1;
        bus.exp_in  = 15'h4000;
        step();
        bus.start = 1'b0;
        reset     = 1'b1;
        step();
        reset = 1'b0;
        check("abort_ready", 64'(bus.ready), 64'd1);
        check("abort_done", 64'(bus.done), 64'd0);
        dones = 0;
        for (int i = 0; i < 14; i++) begin
            if (bus.done) dones++;
            step();
        end
        check("abort_no_done", 64'(dones), 64'd0);
        run_op(64'h0000_0000_3000_0000, 15'h0400, 1'b0);
        for (int i = 0; i < 80; i++) begin
            r = {$urandom(), $urandom()};
            r = r >> $urandom_range(0, 64);
            run_op(r, ($urandom_range(0, 1) == 1) ? 15'($urandom_range(0, 80)) : 15'($urandom()), 1'b0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
